// File: rtl/sindrome_display_mux.sv
// rtl/sindrome_display_mux.sv - multiplexed 7-segment hex display driver with optional error blink (ERR_BLINK_EN)
module sindrome_display_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic                    valid_i,
  input  logic                    err_i,
  output logic [6:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow;

  logic       w_slot_end;
  logic       w_frame_end;
  logic       w_blank;
  logic       w_lit;
  logic [3:0] w_nibble;
  logic [6:0] w_glyph;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
  // cnt=0 is the dead-time cycle of every slot, which suppresses ghosting
  assign w_lit       = (r_cnt != '0) && !w_blank;

  // Prescaler: counts cycles within one digit slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Digit index: advances at the end of each slot, wraps after the last digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_slot_end) begin
      if (r_idx == IDX_LAST) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  // Shadow register: new nibbles become visible on the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (valid_i) begin
      r_shadow <= data_i;
    end
  end

`ifdef ERR_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

  logic            r_err_q;
  logic [BF_W-1:0] r_bcnt;
  logic            r_phase;

  // Error flag is registered so the display never depends on a raw input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_q <= 1'b0;
    end else begin
      r_err_q <= err_i;
    end
  end

  // Blink timer: toggles phase every BLINK_FRAMES scan frames while in error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (!r_err_q) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_frame_end) begin
      if (r_bcnt == BF_LAST) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + BF_W'(1);
      end
    end
  end

  assign w_blank = r_phase;
`else
  // Without the blink feature the error flag has no effect on the display
  logic w_unused_err;
  assign w_unused_err = err_i;
  assign w_blank      = 1'b0;
`endif

  // Select the shadow nibble of the digit currently being scanned
  always_comb begin
    w_nibble = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nibble = r_shadow[4*k +: 4];
      end
    end
  end

  // Active-low hex glyphs, bit 0 = segment a ... bit 6 = segment g
  always_comb begin
    w_glyph = 7'h7F;
    case (w_nibble)
      4'h0: w_glyph = 7'h40;
      4'h1: w_glyph = 7'h79;
      4'h2: w_glyph = 7'h24;
      4'h3: w_glyph = 7'h30;
      4'h4: w_glyph = 7'h19;
      4'h5: w_glyph = 7'h12;
      4'h6: w_glyph = 7'h02;
      4'h7: w_glyph = 7'h78;
      4'h8: w_glyph = 7'h00;
      4'h9: w_glyph = 7'h10;
      4'hA: w_glyph = 7'h08;
      4'hB: w_glyph = 7'h03;
      4'hC: w_glyph = 7'h46;
      4'hD: w_glyph = 7'h21;
      4'hE: w_glyph = 7'h06;
      4'hF: w_glyph = 7'h0E;
      default: w_glyph = 7'h7F;
    endcase
  end

  // Digit enables: only the scanned digit is driven low, and only when lit
  always_comb begin
    an_o = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_lit && (r_idx == IDX_W'(k))) begin
        an_o[k] = 1'b0;
      end
    end
  end

  assign seg_o   = w_lit ? w_glyph : 7'h7F;
  assign frame_o = w_frame_end;

endmodule

// File: tb/tb_sindrome_display_mux.sv
// tb/tb_sindrome_display_mux.sv - self-checking bench for sindrome_display_mux
module tb_sindrome_display_mux;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_i;
  logic        valid_i;
  logic        err_i;
  logic [6:0]  seg_o;
  logic [3:0]  an_o;
  logic        frame_o;

  sindrome_display_mux #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (data_i),
    .valid_i(valid_i),
    .err_i  (err_i),
    .seg_o  (seg_o),
    .an_o   (an_o),
    .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [15:0] data;
    logic        err;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame;
    string      name;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[20];
  int          checks;
  int          failures;
  logic [1:0]  b_cnt;
  logic [1:0]  b_idx;
  logic [15:0] m_shadow;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [3:0] a, input logic [6:0] s, input logic f);
    checks++;
    if (an_o !== a || seg_o !== s || frame_o !== f) begin
      failures++;
      $display("FAIL %s: got an=%b seg=%h frame=%b, expected an=%b seg=%h frame=%b",
               nm, an_o, seg_o, frame_o, a, s, f);
    end
  endtask

  task automatic step(input string nm, input logic r, input logic v, input logic [15:0] d,
                      input logic e, input logic [3:0] a, input logic [6:0] s, input logic f);
    exp_t x;
    rst_n   = r;
    valid_i = v;
    data_i  = d;
    err_i   = e;
    sb.push_back('{a, s, f, nm});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk(x.name, x.an, x.seg, x.frame);
  endtask

  task automatic scan_step(input string nm, input logic e, input logic blank);
    logic [1:0] ncnt;
    logic [1:0] nidx;
    logic       lit;
    logic [3:0] a;
    logic [6:0] s;
    logic       f;
    ncnt = b_cnt + 2'd1;
    nidx = (b_cnt == 2'd3) ? b_idx + 2'd1 : b_idx;
    lit  = (ncnt != 2'd0) && !blank;
    a    = lit ? ~(4'b0001 << nidx) : 4'hF;
    s    = lit ? glyph(m_shadow[nidx*4 +: 4]) : 7'h7F;
    f    = (ncnt == 2'd3) && (nidx == 2'd3);
    step(nm, 1'b1, 1'b0, 16'h5A5A, e, a, s, f);
    b_cnt = ncnt;
    b_idx = nidx;
  endtask

  initial begin
    logic [1:0] ncnt;
    logic [1:0] nidx;
    int         fr;
    int         nfr;
    logic       errv;
    logic       blank;

    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    rst_n    = 1'b0;
    valid_i  = 1'b0;
    data_i   = 16'h0;
    err_i    = 1'b0;

    tbl[0]  = '{1'b0, 1'b0, 16'hA5A5, 1'b0, 4'hF, 7'h7F, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 16'h9999, 1'b0, 4'hF, 7'h7F, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 4'hE, 7'h19, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 16'hA5A5, 1'b0, 4'hE, 7'h19, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'hA5A5, 1'b0, 4'hE, 7'h19, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'hA5A5, 1'b0, 4'hF, 7'h7F, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 16'hA5A5, 1'b0, 4'hD, 7'h30, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 16'hA5A5, 1'b0, 4'hD, 7'h30, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 16'hA5A5, 1'b0, 4'hD, 7'h30, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 16'hA5A5, 1'b0, 4'hF, 7'h7F, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 16'hA5A5, 1'b0, 4'hB, 7'h24, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 16'hA5A5, 1'b0, 4'hB, 7'h24, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 16'hA5A5, 1'b0, 4'hB, 7'h24, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 16'hA5A5, 1'b0, 4'hF, 7'h7F, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 16'hA5A5, 1'b0, 4'h7, 7'h79, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 16'h0000, 1'b0, 4'h7, 7'h40, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 16'hA5A5, 1'b0, 4'h7, 7'h40, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 16'hFEDC, 1'b0, 4'hF, 7'h7F, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 16'hA5A5, 1'b0, 4'hE, 7'h46, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 16'hA5A5, 1'b0, 4'hE, 7'h46, 1'b0};

    #1;
    chk("reset_initial", 4'hF, 7'h7F, 1'b0);

    for (int i = 0; i < 20; i++) begin
      step($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].valid, tbl[i].data, tbl[i].err,
           tbl[i].an, tbl[i].seg, tbl[i].frame);
    end

    // scan continues with FEDC until digit2, cnt=2
    b_cnt    = 2'd2;
    b_idx    = 2'd0;
    m_shadow = 16'hFEDC;
    for (int i = 0; i < 8; i++) begin
      scan_step($sformatf("prerst%0d", i), 1'b0, 1'b0);
    end
    chk("digit2_cnt2", 4'hB, 7'h06, 1'b0);

    // mid-slot asynchronous reset pulse
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_blank", 4'hF, 7'h7F, 1'b0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle", 4'hF, 7'h7F, 1'b0);
    b_cnt    = 2'd0;
    b_idx    = 2'd0;
    m_shadow = 16'h0000;
    scan_step("restart_digit0", 1'b0, 1'b0);

    // error held for six frames, dropped inside frame 7
    fr   = 1;
    errv = 1'b1;
    while (fr <= 8) begin
      if (fr == 7 && b_idx == 2'd0 && b_cnt == 2'd3) errv = 1'b0;
      ncnt = b_cnt + 2'd1;
      nidx = (b_cnt == 2'd3) ? b_idx + 2'd1 : b_idx;
      nfr  = (b_cnt == 2'd3 && b_idx == 2'd3) ? fr + 1 : fr;
`ifdef ERR_BLINK_EN
      blank = (nfr == 3) || (nfr == 4) || (nfr == 7 && nidx == 2'd0);
`else
      blank = 1'b0;
`endif
      scan_step($sformatf("err_f%0d_d%0d_c%0d", nfr, nidx, ncnt), errv, blank);
      fr = nfr;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sindrome_display_mux.md
SINDROME_DISPLAY_MUX -- requirements
Module: sindrome_display_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed 7-segment digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (legal >=2).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, full scan frames per blink half-period (legal >=1).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 data_i  input  4*NUM_DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k.
REQ-008 valid_i  input  1  load strobe; data_i is captured on any clk edge where valid_i=1.
REQ-009 err_i  input  1  uncorrectable-error flag from the Hamming decoder, level-sensitive.
REQ-010 seg_o  output  7  active-low segments, seg_o[0]=a ... seg_o[6]=g.
REQ-011 an_o  output  NUM_DIGITS  active-low digit enables, one-hot-low when lit.
REQ-012 frame_o  output  1  one-cycle pulse at end of each full scan.

Function
REQ-013 SHALL hold a shadow register of 4*NUM_DIGITS bits, loaded from data_i when valid_i=1; the new value is displayed from the next cycle.
REQ-014 SHALL keep a prescaler cnt counting 0..REFRESH_DIV-1, wrapping to 0.
REQ-015 SHALL keep a digit index idx, incremented when cnt=REFRESH_DIV-1, wrapping from NUM_DIGITS-1 to 0.
REQ-016 an_o SHALL be all ones while cnt=0 (one-cycle ghosting dead time per slot), else bit idx low and all others high.
REQ-017 seg_o SHALL be the active-low hex glyph (0-9, A, b, C, d, E, F) of shadow nibble idx while its digit is lit, else 7'h7F.
REQ-018 frame_o SHALL be 1 exactly in the cycle where cnt=REFRESH_DIV-1 and idx=NUM_DIGITS-1.
REQ-019 valid_i coincident with a slot change SHALL apply the new data to the new slot's first lit cycle.
REQ-020 For NUM_DIGITS=1, idx SHALL stay 0 and frame_o SHALL pulse every REFRESH_DIV cycles.
REQ-021 err_i SHALL be registered into err_q each cycle; all outputs derive from registered state only.

Reset
REQ-022 rst_n=0 SHALL immediately clear cnt, idx, shadow, err_q, blink counter and blink phase to 0.
REQ-023 During and after reset until the first lit cycle: an_o all ones, seg_o=7'h7F, frame_o=0.
REQ-024 Reset asserted mid-slot SHALL abort the scan; after release the scan restarts at digit 0, cnt=0.

Configuration
REQ-025 Macro ERR_BLINK_EN defined: a frame counter SHALL toggle blink phase every BLINK_FRAMES frame_o pulses while err_q=1; phase=1 forces an_o all ones and seg_o=7'h7F.
REQ-026 ERR_BLINK_EN defined: err_q=0 SHALL clear blink phase and frame counter in the next cycle.
REQ-027 ERR_BLINK_EN undefined: err_i SHALL be ignored, no blink logic SHALL be synthesised, display never blanks for errors.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-028 Hold rst_n=0 -> an_o=4'b1111, seg_o=7'h7F, frame_o=0; release -> first lit cycle is cycle 1 with an_o=4'b1110.
REQ-029 valid_i=1, data_i=16'h1234 one cycle -> digit0 slot shows seg_o=7'h19 ("4"), digit3 slot shows seg_o=7'h79 ("1") with an_o=4'b0111.
REQ-030 Free-run 16 cycles -> an_o sequence per slot: 1111,1110x3, 1111,1101x3, 1111,1011x3, 1111,0111x3; frame_o high only in cycle 16.
REQ-031 data_i=16'h0000 then 16'hFEDC loaded on cycle cnt=3 -> next lit cycle shows seg_o=7'h46 ("C") on digit0, not "0".
REQ-032 ERR_BLINK_EN, err_i=1 held -> frames 1-2 lit, frames 3-4 an_o=4'b1111, frames 5-6 lit; err_i=0 -> display lit from next slot; without macro -> never blanked.
REQ-033 rst_n pulse low at cnt=2 of digit2 -> outputs blank immediately; after release scan restarts at digit0, shadow reads 0 (seg_o=7'h40).
